// File: rtl/exp_fixed_iter_if.sv
// Operand/result handshake bundle for exp_fixed_iter: operand in on valid/ready,
// result out on valid/ready with saturation flags.
interface exp_fixed_iter_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_x;
    logic                    out_valid;
    logic                    out_ready;
    logic        [WIDTH-1:0] out_y;
    logic                    out_ovf;
    logic                    out_unf;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y, out_ovf, out_unf
    );
endinterface

// File: rtl/exp_fixed_iter.sv
// Sequential fixed-point e^x: x = k*ln2 + r, Horner Taylor series for e^r, then a
// saturating 2^k scale. One operand in flight; valid/ready on both sides.
module exp_fixed_iter #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 24,
    parameter int N_TERMS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    exp_fixed_iter_if.slave io,
    output logic            busy
);
    localparam int KW = WIDTH - FRAC + 2;
    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(N_TERMS + 1);

    localparam longint                  ONE_L     = longint'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] ONE       = WIDTH'(ONE_L);
    localparam logic signed [WIDTH-1:0] LN2_Q     = WIDTH'(longint'(0.6931471805599453 * (2.0 ** FRAC)));
    localparam logic signed [WIDTH-1:0] INV_LN2_Q = WIDTH'(longint'(1.4426950408889634 * (2.0 ** FRAC)));
    localparam logic signed [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    HALF      = PW'(ONE_L >> 1);

    typedef logic [N_TERMS:0][WIDTH-1:0] recip_tab_t;

    // Taylor coefficients 1/i, rounded to nearest; entry 0 is never addressed.
    function automatic recip_tab_t build_recip();
        recip_tab_t t;
        t = '0;
        for (int i = 1; i <= N_TERMS; i++) begin
            t[i] = WIDTH'((ONE_L + longint'(i / 2)) / longint'(i));
        end
        return t;
    endfunction

    localparam recip_tab_t RECIP = build_recip();

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        POLY,
        SCALE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [KW-1:0]    k_q, k_d;
    logic signed [WIDTH-1:0] r_q, r_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic        [IW-1:0]    i_q, i_d;
    logic        [WIDTH-1:0] y_q, y_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    // Range reduction: k = floor(x/ln2) from a double-width product, r clamped to [0, ln2).
    logic signed [PW-1:0]    kx_prod;
    logic signed [PW-1:0]    kln2;
    logic signed [PW-1:0]    r_wide;
    logic signed [KW-1:0]    k_red;
    logic signed [WIDTH-1:0] r_red;

    always_comb begin
        kx_prod = PW'(x_q) * PW'(INV_LN2_Q);
        k_red   = KW'(kx_prod >>> (2 * FRAC));
        kln2    = PW'(k_red) * PW'(LN2_Q);
        r_wide  = PW'(x_q) - kln2;
        if (r_wide[PW-1]) begin
            r_red = '0;
        end else if (r_wide >= PW'(LN2_Q)) begin
            r_red = LN2_Q - WIDTH'(1);
        end else begin
            r_red = r_wide[WIDTH-1:0];
        end
    end

    // One Horner step: acc = 1 + rnd(rnd(acc*r) * (1/i)).
    logic signed [PW-1:0]    p_ar;
    logic signed [PW-1:0]    p_rc;
    logic signed [WIDTH-1:0] t_ar;
    logic signed [WIDTH-1:0] t_rc;
    logic signed [WIDTH-1:0] acc_step;

    always_comb begin
        p_ar     = PW'(acc_q) * PW'(r_q);
        t_ar     = WIDTH'((p_ar + HALF) >>> FRAC);
        p_rc     = PW'(t_ar) * PW'($signed(RECIP[i_q]));
        t_rc     = WIDTH'((p_rc + HALF) >>> FRAC);
        acc_step = ONE + t_rc;
    end

    // 2^k scale. acc is e^r >= ONE here, so both shifts work on a positive magnitude.
    logic [KW-1:0]    nk;
    logic [PW-1:0]    up_wide;
    logic [PW-1:0]    dn_wide;
    logic [WIDTH-1:0] y_sc;
    logic             ovf_sc;
    logic             unf_sc;

    always_comb begin
        y_sc    = '0;
        ovf_sc  = 1'b0;
        unf_sc  = 1'b0;
        nk      = KW'(-k_q);
        up_wide = PW'(unsigned'(acc_q)) << unsigned'(k_q);
        dn_wide = (PW'(unsigned'(acc_q)) + (PW'(1) << (nk - KW'(1)))) >> nk;
        if (!k_q[KW-1]) begin
            if ((k_q > KW'(WIDTH - 1)) || (up_wide > PW'(MAX_POS))) begin
                y_sc   = MAX_POS;
                ovf_sc = 1'b1;
            end else begin
                y_sc = up_wide[WIDTH-1:0];
            end
        end else if ((nk > KW'(FRAC + 1)) || (dn_wide == '0)) begin
            unf_sc = 1'b1;
        end else begin
            y_sc = dn_wide[WIDTH-1:0];
        end
    end

    // NOTE: every _d is given its hold value before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        k_d     = k_q;
        r_d     = r_q;
        acc_d   = acc_q;
        i_d     = i_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    x_d     = io.in_x;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                k_d     = k_red;
                r_d     = r_red;
                acc_d   = ONE;
                i_d     = IW'(N_TERMS);
                state_d = POLY;
            end
            POLY: begin
                acc_d = acc_step;
                i_d   = i_q - IW'(1);
                if (i_q == IW'(1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                y_d     = y_sc;
                ovf_d   = ovf_sc;
                unf_d   = unf_sc;
                state_d = DONE;
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            k_q     <= k_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.out_y     = y_q;
    assign io.out_ovf   = ovf_q;
    assign io.out_unf   = unf_q;
    assign busy         = (state_q != IDLE);

endmodule
